probe_cmd_arbiter: RTL

PROBE_CMD_ARBITER -- requirements
Module: probe_cmd_arbiter

---
 rtl/probe_arb_pkg.sv | 19 +
 rtl/probe_cmd_arbiter_if.sv | 20 ++
 rtl/probe_rr_arb2.sv | 18 +
 rtl/probe_cmd_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/probe_arb_pkg.sv
// probe_arb_pkg: shared FSM states, command classes, command byte map and class decoder
//   Used by probe_cmd_arbiter (state/class types, cmd_class()).
package probe_arb_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_WACK, ST_PAYLOAD, ST_RESP} state_t;
    typedef enum logic [1:0] {CLS_SINGLE, CLS_READ, CLS_WRITE} cmd_cls_t;
    // Probe command byte groups: READ expects one response byte, WRITE carries one payload byte
    localparam logic [7:0] CMD_RD_A_LO = 8'h02, CMD_RD_A_HI = 8'h09;
    localparam logic [7:0] CMD_WR_A_LO = 8'h0A, CMD_WR_A_HI = 8'h0D;
    localparam logic [7:0] CMD_RD_B_LO = 8'h0E, CMD_RD_B_HI = 8'h11;
    localparam logic [7:0] CMD_WR_B_LO = 8'h12, CMD_WR_B_HI = 8'h15;
    localparam logic [7:0] CMD_RD_C = 8'h16, CMD_WR_C = 8'h17;
    localparam logic [7:0] CMD_RD_D = 8'h18, CMD_WR_D = 8'h19;
    function automatic cmd_cls_t cmd_class(input logic [7:0] b);
        return ((b >= CMD_RD_A_LO && b <= CMD_RD_A_HI) || (b >= CMD_RD_B_LO && b <= CMD_RD_B_HI) ||
                b == CMD_RD_C || b == CMD_RD_D) ? CLS_READ :
               ((b >= CMD_WR_A_LO && b <= CMD_WR_A_HI) || (b >= CMD_WR_B_LO && b <= CMD_WR_B_HI) ||
                b == CMD_WR_C || b == CMD_WR_D) ? CLS_WRITE : CLS_SINGLE;
    endfunction
endpackage

// File: rtl/probe_cmd_arbiter_if.sv
// probe_cmd_arbiter_if: byte streams around the probe command arbiter
//   s0/s1: command streams from requesters, m0/m1: response streams to requesters,
//   p_rx: bytes into the probe, p_tx: response bytes from the probe.
//   master: arbiter side, slave: requesters + probe side.
interface probe_cmd_arbiter_if;
    logic       s0_valid, s0_ready, s1_valid, s1_ready;
    logic [7:0] s0_data, s1_data;
    logic       m0_valid, m0_ready, m1_valid, m1_ready;
    logic [7:0] m0_data, m1_data;
    logic       p_rx_valid, p_rx_ready, p_tx_valid, p_tx_ready;
    logic [7:0] p_rx_data, p_tx_data;
    modport master (
        input  s0_valid, s0_data, s1_valid, s1_data, m0_ready, m1_ready, p_rx_ready, p_tx_valid, p_tx_data,
        output s0_ready, s1_ready, m0_valid, m0_data, m1_valid, m1_data, p_rx_valid, p_rx_data, p_tx_ready
    );
    modport slave (
        output s0_valid, s0_data, s1_valid, s1_data, m0_ready, m1_ready, p_rx_ready, p_tx_valid, p_tx_data,
        input  s0_ready, s1_ready, m0_valid, m0_data, m1_valid, m1_data, p_rx_valid, p_rx_data, p_tx_ready
    );
endinterface

// File: rtl/probe_rr_arb2.sv
// probe_rr_arb2: two-way round-robin arbiter
//   clk, m_aresetn (async, active-low); i_req: request per requester; i_en: arbitration allowed;
//   o_gnt: one-hot winner this cycle (0 when disabled or no request).
module probe_rr_arb2 (
    input  logic       clk,
    input  logic       m_aresetn,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);
    // requester favoured on contention; flips to the other one after every grant
    logic r_ptr;
    assign o_gnt = !i_en ? 2'b00 : i_req == 2'b11 ? (r_ptr ? 2'b10 : 2'b01) : i_req;
    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) r_ptr <= 1'b0;
        else if (|o_gnt) r_ptr <= o_gnt[0];
    end
endmodule

// File: rtl/probe_cmd_arbiter.sv
// probe_cmd_arbiter: shares one probe command port between two requesters, one command at a time
//   clk, m_aresetn (async, active-low); bus: s0/s1 command in, m0/m1 response out, p_rx/p_tx probe side;
//   grant: one-hot owner, 0 when idle.
//   Optional (PROBE_ARB_STATS_EN): cnt0/cnt1 count completed commands per requester, wrapping at 2^CNT_W.
module probe_cmd_arbiter
    import probe_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       m_aresetn,
    probe_cmd_arbiter_if.master        bus,
    output logic [1:0]                 grant
`ifdef PROBE_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]           cnt0,
    output logic [CNT_W-1:0]           cnt1
`endif
);
    state_t     r_state, w_next;
    cmd_cls_t   r_cls;
    logic [1:0] r_grant, w_win;
    logic [7:0] r_hold, w_sel_data;
    logic       r_is_pay, w_pay, w_done, w_resp, w_pay_st;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    // arbitration only in IDLE and never while reset is held, so no ready leaks during reset
    probe_rr_arb2 u_arb (
        .clk    (clk),
        .m_aresetn(m_aresetn),
        .i_req  ({bus.s1_valid, bus.s0_valid}),
        .i_en   (m_aresetn && r_state == ST_IDLE),
        .o_gnt  (w_win)
    );

    assign w_pay_st   = r_state == ST_PAYLOAD;
    assign w_pay      = w_pay_st && |(r_grant & {bus.s1_valid, bus.s0_valid});
    assign w_sel_data = (w_win[0] || (w_pay_st && r_grant[0])) ? bus.s0_data : bus.s1_data;
    assign w_resp     = r_state == ST_RESP;
    assign w_done     = r_state != ST_IDLE && w_next == ST_IDLE;

    assign bus.s0_ready   = w_win[0] || (w_pay_st && r_grant[0]);
    assign bus.s1_ready   = w_win[1] || (w_pay_st && r_grant[1]);
    assign bus.p_rx_valid = r_state == ST_SEND;
    assign bus.p_rx_data  = r_hold;
    assign bus.m0_valid   = w_resp && r_grant[0] && bus.p_tx_valid;
    assign bus.m1_valid   = w_resp && r_grant[1] && bus.p_tx_valid;
    assign bus.m0_data    = (w_resp && r_grant[0]) ? bus.p_tx_data : 8'h00;
    assign bus.m1_data    = (w_resp && r_grant[1]) ? bus.p_tx_data : 8'h00;
    assign bus.p_tx_ready = w_resp && (r_grant[0] ? bus.m0_ready : bus.m1_ready);
    assign grant          = r_grant;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    w_next = |w_win ? ST_SEND : ST_IDLE;
            ST_SEND:    w_next = ST_WACK;
            // a payload byte always finishes the command; otherwise the command class decides
            ST_WACK:    w_next = !bus.p_rx_ready ? ST_WACK :
                                 (r_is_pay || r_cls == CLS_SINGLE) ? ST_IDLE :
                                 r_cls == CLS_WRITE ? ST_PAYLOAD : ST_RESP;
            ST_PAYLOAD: w_next = w_pay ? ST_SEND : ST_PAYLOAD;
            ST_RESP:    w_next = (bus.p_tx_valid && bus.p_tx_ready) ? ST_IDLE : ST_RESP;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            r_state  <= ST_IDLE;
            r_grant  <= 2'b00;
            r_cls    <= CLS_SINGLE;
            r_hold   <= 8'h00;
            r_is_pay <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_grant  <= |w_win ? w_win : w_done ? 2'b00 : r_grant;
            r_cls    <= |w_win ? cmd_class(w_sel_data) : r_cls;
            r_is_pay <= |w_win ? 1'b0 : w_pay ? 1'b1 : r_is_pay;
            r_hold   <= (|w_win || w_pay) ? w_sel_data : r_hold;
        end
    end

`ifdef PROBE_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0, r_cnt1;
    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            r_cnt0 <= r_cnt0 + CNT_W'(w_done && r_grant[0]);
            r_cnt1 <= r_cnt1 + CNT_W'(w_done && r_grant[1]);
        end
    end
    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif
endmodule
